// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
// The top module and the arbiter both import this package.
package mux_pkg;

  // SEL_MODE encodings
  localparam int unsigned SEL_RR  = 0;
  localparam int unsigned SEL_EXT = 1;

  typedef logic [0:0] mux_state_t;

  localparam mux_state_t StArb  = 1'b0;
  localparam mux_state_t StLock = 1'b1;

  // Channel index width; kept at least one bit wide.
  function automatic int unsigned calc_ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: grants the first requester found searching
// upward from ptr+1, wrapping around to ptr itself last.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CH_W   = calc_ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              grant_vld,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    // Walk farthest-first so the requester nearest after ptr is written last and wins.
    for (int off = int'(NUM_CH); off >= 1; off--) begin
      idx = CH_W'((int'(ptr) + off) % int'(NUM_CH));
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 packet-aware stream multiplexer with a registered output stage.
// Arbitrates per packet, either round-robin or by an external channel select.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SEL_MODE = SEL_RR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  input  logic [NUM_CH-1:0]            in_last,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [calc_ch_w(NUM_CH)-1:0] sel,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [calc_ch_w(NUM_CH)-1:0] out_ch,
  input  logic                         out_ready
);

  localparam int unsigned CH_W     = calc_ch_w(NUM_CH);
  localparam int unsigned SEL_SPAN = 1 << CH_W;

  mux_state_t      state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic            active_q;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic              arb_vld;
  logic [CH_W-1:0]   arb_idx;
  logic              win_vld;
  logic [CH_W-1:0]   winner;
  logic [DATA_W-1:0] win_data;
  logic              win_last;
  logic              slot_free;
  logic              xfer;
  logic [SEL_SPAN-1:0] ch_present;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_vld (arb_vld),
    .grant_idx (arb_idx)
  );

  // Marks select codes that name a real channel; the rest mean no winner.
  always_comb begin
    ch_present = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_present[i] = 1'b1;
    end
  end

  always_comb begin
    win_vld = 1'b0;
    winner  = '0;
    if (state_q == StLock) begin
      win_vld = 1'b1;
      winner  = lock_ch_q;
    end else if (SEL_MODE == SEL_EXT) begin
      win_vld = ch_present[sel];
      winner  = sel;
    end else begin
      win_vld = arb_vld;
      winner  = arb_idx;
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (winner == CH_W'(i)) begin
        win_data = in_data[i*DATA_W +: DATA_W];
        win_last = in_last[i];
      end
    end
  end

  assign slot_free = ~out_valid_q | out_ready;

  // active_q keeps in_ready low through reset without a combinational path from rst_n.
  always_comb begin
    in_ready = '0;
    if (active_q && slot_free && win_vld) begin
      in_ready[winner] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_last_d  = win_last;
      out_ch_d    = winner;
      ptr_d       = winner;
      if (state_q == StArb && !win_last) begin
        state_d   = StLock;
        lock_ch_d = winner;
      end else if (state_q == StLock && win_last) begin
        state_d = StArb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArb;
      ptr_q       <= CH_W'(NUM_CH - 1);
      lock_ch_q   <= '0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      active_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of input channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, data width per channel.
REQ-003 SHALL have parameter SEL_MODE, default 0: 0 = round-robin arbitration, 1 = external select.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, NUM_CH bits: per-channel valid.
REQ-007 SHALL have port in_data, input, NUM_CH*DATA_W bits: channel i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_last, input, NUM_CH bits: per-channel end-of-packet flag.
REQ-009 SHALL have port in_ready, output, NUM_CH bits: per-channel accept.
REQ-010 SHALL have port sel, input, CH_W = clog2(NUM_CH) bits: channel choice, used only when SEL_MODE = 1.
REQ-011 SHALL have port out_valid, output, 1 bit.
REQ-012 SHALL have port out_data, output, DATA_W bits.
REQ-013 SHALL have port out_last, output, 1 bit.
REQ-014 SHALL have port out_ch, output, CH_W bits: source channel of the current output beat.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-016 SHALL transfer an input beat on channel i when in_valid[i] and in_ready[i] are both 1 at a rising clk edge.
REQ-017 SHALL transfer an output beat when out_valid and out_ready are both 1.
REQ-018 SHALL hold out_data, out_last and out_ch stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL register the output: a beat accepted at edge N SHALL appear on the outputs after edge N, giving 1-cycle latency.
REQ-020 SHALL define slot_free = ~out_valid | out_ready.
REQ-021 SHALL assert at most one in_ready bit per cycle: in_ready[g] = slot_free & (winner == g), all other bits 0; this sustains full throughput of one beat per cycle.
REQ-022 SHALL implement a two-state FSM:
- ARB: a winner is chosen each cycle.
- LOCK: the winner is held at the locked channel.
REQ-023 SHALL move ARB -> LOCK when a beat with in_last = 0 transfers.
REQ-024 SHALL move LOCK -> ARB when the locked channel transfers a beat with in_last = 1.
REQ-025 SHALL keep a single-beat packet (in_last = 1 taken in ARB) in ARB.
REQ-026 In ARB with SEL_MODE = 0, SHALL pick as winner the first valid channel searching upward from (ptr+1) mod NUM_CH, wrapping around.
REQ-027 SHALL update ptr to the granted channel only on an input transfer.
REQ-028 In ARB with SEL_MODE = 1, SHALL use sel as the winner; if in_valid[sel] = 0, no transfer occurs.
REQ-029 SHALL ignore sel changes while in LOCK.
REQ-030 SHALL treat a sel value >= NUM_CH as no winner, so no transfer occurs.
REQ-031 SHALL make no transfer and leave ptr unchanged when no channel is valid.
REQ-032 In LOCK, SHALL assert in_ready only to the locked channel, even if it is invalid, and other channels SHALL wait.
REQ-033 SHALL treat an in_valid drop mid-packet as a bubble, not a packet end.

Reset
REQ-034 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_last = 0, out_ch = 0, in_ready = 0, FSM = ARB, and ptr = NUM_CH-1, so channel 0 has first priority after reset.
REQ-035 SHALL, when reset is asserted mid-packet, discard the packet and release the lock; no partial-beat state SHALL survive.
REQ-036 SHALL deassert reset with no combinational dependence on rst_n for in_ready beyond the registered state.

Structure
REQ-037 SHALL take CH_W, the FSM state typedef (ARB/LOCK) and the SEL_MODE encodings from shared package mux_pkg.
REQ-038 SHALL place the round-robin priority search in sub-module rr_arbiter (inputs req, ptr; outputs grant_vld, grant_idx); the FSM, lock and output register stay in the top module.

Verification
REQ-039 SHALL cover: NUM_CH = 8, SEL_MODE = 0, all channels valid with single-beat packets, out_ready = 1 -> out_ch sequence 0,1,2,...,7,0 with one beat per cycle.
REQ-040 SHALL cover: channel 3 sends a 4-beat packet 0xA0..0xA3 while channel 5 is valid throughout -> all four ch3 beats contiguous, then ch5 granted.
REQ-041 SHALL cover: out_ready held at 0 for 3 cycles with out_data = 0x55 -> output stable and in_ready = 0 throughout, then the next beat follows the cycle after out_ready = 1.
REQ-042 SHALL cover: SEL_MODE = 1, sel = 6, d = 8'h40 valid only on ch6 -> out_data = 8'h40 and out_ch = 6; sel = 2 with ch2 invalid -> out_valid falls.
REQ-043 SHALL cover: rst_n pulsed low during LOCK on ch1 -> out_valid = 0, and after release ch0 wins when all channels are valid.
REQ-044 SHALL cover: only ch7 valid after ptr = 7 -> wrap-around search grants ch7.
